// File: rtl/lighthouse_line_rx_pkg.sv
// Shared constants and state encoding for the lighthouse line receiver.
// Latency: none (declarations only).
// Backpressure: not applicable.
package lighthouse_line_rx_pkg;

    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    localparam int REC_W = 28;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        FIELD_A = 3'd1,
        SPACE   = 3'd2,
        FIELD_B = 3'd3,
        EOL     = 3'd4,
        SKIP    = 3'd5
    } state_t;

    // Either line terminator ends a line.
    function automatic logic is_term(input logic [7:0] b);
        return (b == ASCII_LF) || (b == ASCII_CR);
    endfunction

endpackage

// File: rtl/lighthouse_line_rx_ascii_hex_decode.sv
// Maps one ASCII byte to {valid, nibble}; lowercase a-f accepted when ACCEPT_LOWER != 0.
// Latency: purely combinational.
// Backpressure: none.
// Ports: chr (byte in), valid (byte is a hex digit), nibble (its value, 0 when invalid).
module ascii_hex_decode #(
    parameter int ACCEPT_LOWER = 1
) (
    input  logic [7:0] chr,
    output logic       valid,
    output logic [3:0] nibble
);

    always_comb begin
        valid  = 1'b0;
        nibble = 4'd0;
        if (chr >= 8'h30 && chr <= 8'h39) begin
            valid  = 1'b1;
            nibble = chr[3:0];
        end else if (chr >= 8'h41 && chr <= 8'h46) begin
            // 'A' is 0x41: low nibble 1..6 plus 9 gives 10..15.
            valid  = 1'b1;
            nibble = chr[3:0] + 4'd9;
        end else if ((ACCEPT_LOWER != 0) && chr >= 8'h61 && chr <= 8'h66) begin
            valid  = 1'b1;
            nibble = chr[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/lighthouse_line_rx.sv
// Parses "D0D1D2 D3D4D5D6<TERM>" ASCII lines into a 28-bit lighthouse record.
// Latency: record/record_strobe and error_strobe register one cycle after the deciding byte.
// Backpressure: none; every data_strobe byte is consumed, idle cycles change nothing.
// Ports: clk, reset (async active-low), data/data_strobe (byte stream in),
//        record + lighthouse/axis/data_bit/angle (last good record), record_strobe,
//        error_strobe, error_count (saturating malformed-line count).
module lighthouse_line_rx
    import lighthouse_line_rx_pkg::*;
#(
    parameter int ERR_BITS     = 16,
    parameter int ACCEPT_LOWER = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          data,
    input  logic                data_strobe,
    output logic [REC_W-1:0]    record,
    output logic                lighthouse,
    output logic                axis,
    output logic                data_bit,
    output logic [19:0]         angle,
    output logic                record_strobe,
    output logic                error_strobe,
    output logic [ERR_BITS-1:0] error_count
);

    state_t           state, state_nxt;
    logic [2:0]       cnt, cnt_nxt;
    logic [REC_W-1:0] shreg;

    logic       hex_vld;
    logic [3:0] hex_nib;
    logic       do_load, do_shift, do_commit, do_err;
    logic       fields_ok;

    ascii_hex_decode #(
        .ACCEPT_LOWER(ACCEPT_LOWER)
    ) u_hex (
        .chr   (data),
        .valid (hex_vld),
        .nibble(hex_nib)
    );

    // D0 lands in [27:24] and D1 in [23:20] after seven digits; D0 must be
    // 0..3 and D1 0..1, so the bits the record pads with zeros must be clear.
    assign fields_ok = (shreg[27:26] == 2'b00) && (shreg[23:21] == 3'b000);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= HUNT;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt holds the number of digits taken so far in the line (1..7).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_load   = 1'b0;
        do_shift  = 1'b0;
        do_commit = 1'b0;
        do_err    = 1'b0;
        if (data_strobe) begin
            case (state)
                HUNT: begin
                    if (hex_vld) begin
                        do_load   = 1'b1;
                        cnt_nxt   = 3'd1;
                        state_nxt = FIELD_A;
                    end else if (!is_term(data)) begin
                        do_err    = 1'b1;
                        state_nxt = SKIP;
                    end
                end
                FIELD_A: begin
                    if (hex_vld) begin
                        do_shift = 1'b1;
                        cnt_nxt  = cnt + 3'd1;
                        if (cnt == 3'd2) begin
                            state_nxt = SPACE;
                        end
                    end else begin
                        do_err    = 1'b1;
                        cnt_nxt   = 3'd0;
                        state_nxt = SKIP;
                    end
                end
                SPACE: begin
                    if (data == ASCII_SP) begin
                        state_nxt = FIELD_B;
                    end else begin
                        do_err    = 1'b1;
                        cnt_nxt   = 3'd0;
                        state_nxt = SKIP;
                    end
                end
                FIELD_B: begin
                    if (hex_vld) begin
                        do_shift = 1'b1;
                        cnt_nxt  = cnt + 3'd1;
                        if (cnt == 3'd6) begin
                            state_nxt = EOL;
                        end
                    end else begin
                        do_err    = 1'b1;
                        cnt_nxt   = 3'd0;
                        state_nxt = SKIP;
                    end
                end
                EOL: begin
                    cnt_nxt = 3'd0;
                    if (is_term(data)) begin
                        // A terminator still ends the line when the fields are
                        // out of range, so parsing resumes in HUNT, not SKIP.
                        if (fields_ok) begin
                            do_commit = 1'b1;
                        end else begin
                            do_err = 1'b1;
                        end
                        state_nxt = HUNT;
                    end else begin
                        do_err    = 1'b1;
                        state_nxt = SKIP;
                    end
                end
                SKIP: begin
                    if (is_term(data)) begin
                        state_nxt = HUNT;
                    end
                end
                default: begin
                    cnt_nxt   = 3'd0;
                    state_nxt = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg         <= '0;
            record        <= '0;
            record_strobe <= 1'b0;
            error_strobe  <= 1'b0;
            error_count   <= '0;
        end else begin
            if (do_load) begin
                shreg <= {{(REC_W-4){1'b0}}, hex_nib};
            end else if (do_shift) begin
                shreg <= {shreg[REC_W-5:0], hex_nib};
            end
            if (do_commit) begin
                record <= shreg;
            end
            record_strobe <= do_commit;
            error_strobe  <= do_err;
            if (do_err && (error_count != {ERR_BITS{1'b1}})) begin
                error_count <= error_count + 1'b1;
            end
        end
    end

    assign lighthouse = record[25];
    assign axis       = record[24];
    assign data_bit   = record[20];
    assign angle      = record[19:0];

endmodule

// File: tb/tb_lighthouse_line_rx.sv
// Bench for lighthouse_line_rx: three instances (default, uppercase-only, 2-bit counter).
// Latency: expects strobes registered one cycle after the deciding byte.
// Backpressure: none; bytes are sent back-to-back or with random idle gaps.
module tb_lighthouse_line_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic [2:0] stb;
    int         sel;

    always #5 clk = ~clk;

    logic [27:0] rec_a, rec_b, rec_c;
    logic        lh_a, lh_b, lh_c, ax_a, ax_b, ax_c, db_a, db_b, db_c;
    logic [19:0] ang_a, ang_b, ang_c;
    logic        rs_a, rs_b, rs_c, es_a, es_b, es_c;
    logic [15:0] ec_a, ec_b;
    logic [1:0]  ec_c;

    lighthouse_line_rx u_dut_a (
        .clk(clk), .reset(reset), .data(data), .data_strobe(stb[0]),
        .record(rec_a), .lighthouse(lh_a), .axis(ax_a), .data_bit(db_a), .angle(ang_a),
        .record_strobe(rs_a), .error_strobe(es_a), .error_count(ec_a)
    );

    lighthouse_line_rx #(.ERR_BITS(16), .ACCEPT_LOWER(0)) u_dut_b (
        .clk(clk), .reset(reset), .data(data), .data_strobe(stb[1]),
        .record(rec_b), .lighthouse(lh_b), .axis(ax_b), .data_bit(db_b), .angle(ang_b),
        .record_strobe(rs_b), .error_strobe(es_b), .error_count(ec_b)
    );

    lighthouse_line_rx #(.ERR_BITS(2), .ACCEPT_LOWER(1)) u_dut_c (
        .clk(clk), .reset(reset), .data(data), .data_strobe(stb[2]),
        .record(rec_c), .lighthouse(lh_c), .axis(ax_c), .data_bit(db_c), .angle(ang_c),
        .record_strobe(rs_c), .error_strobe(es_c), .error_count(ec_c)
    );

    // Outputs of the instance currently under test.
    logic [27:0] m_rec;
    logic        m_lh, m_ax, m_db, m_rs, m_es;
    logic [19:0] m_ang;
    logic [15:0] m_ec;

    always_comb begin
        case (sel)
            1: begin
                m_rec = rec_b; m_lh = lh_b; m_ax = ax_b; m_db = db_b; m_ang = ang_b;
                m_rs = rs_b; m_es = es_b; m_ec = ec_b;
            end
            2: begin
                m_rec = rec_c; m_lh = lh_c; m_ax = ax_c; m_db = db_c; m_ang = ang_c;
                m_rs = rs_c; m_es = es_c; m_ec = {14'd0, ec_c};
            end
            default: begin
                m_rec = rec_a; m_lh = lh_a; m_ax = ax_a; m_db = db_a; m_ang = ang_a;
                m_rs = rs_a; m_es = es_a; m_ec = ec_a;
            end
        endcase
    end

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // kind: 0 = no event, 1 = record commit, 2 = error
    typedef struct {
        int          sel;
        string       txt;
        int          kind;
        logic [27:0] rec_after;
        int          ecnt_after;
    } vec_t;

    typedef struct {
        int          kind;
        logic [27:0] rec;
    } ev_t;

    vec_t vecs[$];
    ev_t  sbq[$];

    function automatic void add(input int s, input string t, input int k,
                                input logic [27:0] r, input int e);
        vec_t v;
        v.sel = s; v.txt = t; v.kind = k; v.rec_after = r; v.ecnt_after = e;
        vecs.push_back(v);
    endfunction

    function automatic void expect_ev(input int k, input logic [27:0] r);
        ev_t e;
        e.kind = k;
        e.rec  = r;
        sbq.push_back(e);
    endfunction

    // Scoreboard monitor: every strobe pops one expected event.
    logic prev_rs = 1'b0, prev_es = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_rs = 1'b0;
            prev_es = 1'b0;
        end else begin
            if (m_rs && m_es) chk("strobes_overlap", 32'd1, 32'd0);
            if (m_rs && prev_rs) chk("record_strobe_width", 32'd2, 32'd1);
            if (m_es && prev_es) chk("error_strobe_width", 32'd2, 32'd1);
            if (m_rs || m_es) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_strobe", {30'd0, m_es, m_rs}, 32'd0);
                end else begin
                    ev_t e;
                    e = sbq.pop_front();
                    chk("event_kind", m_rs ? 32'd1 : 32'd2, e.kind);
                    if (m_rs && e.kind == 1) begin
                        chk("record", {4'd0, m_rec}, {4'd0, e.rec});
                        chk("angle", {12'd0, m_ang}, {12'd0, e.rec[19:0]});
                        chk("lighthouse", {31'd0, m_lh}, {31'd0, e.rec[25]});
                        chk("axis", {31'd0, m_ax}, {31'd0, e.rec[24]});
                        chk("data_bit", {31'd0, m_db}, {31'd0, e.rec[20]});
                    end
                end
            end
            prev_rs = m_rs;
            prev_es = m_es;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int s, input bit gaps);
        data   = b;
        stb[s] = 1'b1;
        @(posedge clk);
        #1;
        stb  = '0;
        data = 8'($urandom);
        if (gaps && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_str(input string t, input int s, input bit gaps);
        for (int i = 0; i < t.len(); i++) begin
            send_byte(t[i], s, gaps);
        end
    endtask

    task automatic settle_and_check(input string tag, input logic [27:0] r, input int e);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_pending_events"}, sbq.size(), 32'd0);
        sbq.delete();
        chk({tag, "_record_held"}, {4'd0, m_rec}, {4'd0, r});
        chk({tag, "_error_count"}, {16'd0, m_ec}, e);
    endtask

    initial begin
        reset = 1'b0;
        data  = 8'd0;
        stb   = '0;
        sel   = 0;

        add(0, "31A BCDE\n\015", 1, 28'h31ABCDE, 0);
        add(0, "00a bcde\015",   1, 28'h00ABCDE, 0);
        add(0, "41A BCDE\n",     2, 28'h00ABCDE, 1);
        add(0, "201 2345\n",     1, 28'h2012345, 1);
        add(0, "31AXBCDE\n",     2, 28'h2012345, 2);
        add(0, "00F FFFF\n",     1, 28'h00FFFFF, 2);
        add(0, "12A BCDE\n",     2, 28'h00FFFFF, 3);
        add(0, "\n\015\n",       0, 28'h00FFFFF, 3);
        add(0, "311 00000\n",    2, 28'h00FFFFF, 4);
        add(0, "G00 0000\n",     2, 28'h00FFFFF, 5);
        add(0, "30F 0000\015",   1, 28'h30F0000, 5);
        add(0, "1 2\n",          2, 28'h30F0000, 6);
        add(0, "01F 0000\n",     1, 28'h01F0000, 6);
        add(1, "00a bcde\015",   2, 28'h0000000, 1);
        add(1, "00A BCDE\015",   1, 28'h00ABCDE, 1);
        add(2, "ZZ\n",           2, 28'h0000000, 1);
        add(2, "1 \n",           2, 28'h0000000, 2);
        add(2, "12x\n",          2, 28'h0000000, 3);
        add(2, "123X\n",         2, 28'h0000000, 3);
        add(2, "9\t\n",          2, 28'h0000000, 3);

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("reset_record", {4'd0, m_rec}, 32'd0);
            chk("reset_error_count", {16'd0, m_ec}, 32'd0);
            chk("reset_strobes", {30'd0, m_rs, m_es}, 32'd0);
        end
        sel = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            if (vecs[i].kind != 0) expect_ev(vecs[i].kind, vecs[i].rec_after);
            send_str(vecs[i].txt, vecs[i].sel, 1'b1);
            settle_and_check($sformatf("vec%0d", i), vecs[i].rec_after, vecs[i].ecnt_after);
        end

        // Commit latency: strobe appears on the edge that samples TERM.
        sel = 0;
        expect_ev(1, 28'h2012345);
        send_str("201 2345", 0, 1'b0);
        chk("no_strobe_before_term", {31'd0, m_rs}, 32'd0);
        send_byte(8'h0A, 0, 1'b0);
        chk("record_strobe_latency", {31'd0, m_rs}, 32'd1);
        chk("record_on_strobe", {4'd0, m_rec}, 32'h2012345);
        @(posedge clk);
        #1;
        chk("record_strobe_drop", {31'd0, m_rs}, 32'd0);

        // Error latency: strobe on the edge that samples the bad byte.
        expect_ev(2, 28'h0);
        send_str("31A", 0, 1'b0);
        send_byte("X", 0, 1'b0);
        chk("error_strobe_latency", {31'd0, m_es}, 32'd1);
        send_str("BCDE\n", 0, 1'b0);
        chk("error_strobe_drop", {31'd0, m_es}, 32'd0);
        settle_and_check("skip_line", 28'h2012345, 7);

        // Reset in the middle of a line discards it.
        send_str("31A BC", 0, 1'b1);
        reset = 1'b0;
        #3;
        chk("midline_reset_record", {4'd0, m_rec}, 32'd0);
        chk("midline_reset_fields", {9'd0, m_lh, m_ax, m_db, m_ang}, 32'd0);
        chk("midline_reset_error_count", {16'd0, m_ec}, 32'd0);
        chk("midline_reset_strobes", {30'd0, m_rs, m_es}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        expect_ev(1, 28'h1000001);
        send_str("100 0001\n", 0, 1'b1);
        settle_and_check("after_reset", 28'h1000001, 0);
        chk("after_reset_axis", {31'd0, m_ax}, 32'd1);
        chk("after_reset_angle", {12'd0, m_ang}, 32'h00001);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/lighthouse_line_rx.md
LIGHTHOUSE_LINE_RX -- requirements
Module: lighthouse_line_rx

Interface
REQ-001 Parameter ERR_BITS, default 16: width of the saturating error counter.
REQ-002 Parameter ACCEPT_LOWER, default 1: when 1, the digits a-f are also accepted as hex digits.
REQ-003 clk  input  1  single clock; all logic is on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 data  input  8  received byte from uart_rx.
REQ-006 data_strobe  input  1  data is valid for this cycle; no backpressure is possible.
REQ-007 record  output  28  last good record, equal to {2'b0, lighthouse, axis, 3'b0, data_bit, angle}.
REQ-008 lighthouse, axis, data_bit  output  1 each  decoded fields of record.
REQ-009 angle  output  20  decoded angle field.
REQ-010 record_strobe  output  1  one-cycle pulse when record and the field outputs update.
REQ-011 error_strobe  output  1  one-cycle pulse when a malformed line is detected.
REQ-012 error_count  output  ERR_BITS  count of malformed lines; saturates at all-ones.

Function
REQ-013 Line grammar: D0 D1 D2 SP D3 D4 D5 D6 TERM.
  - D = ASCII hex digit.
  - SP = 0x20.
  - TERM = 0x0A or 0x0D.
REQ-014 Decode order: D0 = {2'b0, lighthouse, axis}, D1 = {3'b0, data_bit}, D2..D6 = angle[19:0] MSB first.
REQ-015 States: HUNT, FIELD_A, SPACE, FIELD_B, EOL, SKIP.
  - A 3-bit digit counter and a 28-bit shift register accompany the states.
REQ-016 State transitions:
  - HUNT: TERM is ignored; a hex digit loads the shift register and moves to FIELD_A with count=1; any other byte is an error and moves to SKIP.
  - FIELD_A: a hex digit shifts in; after the 3rd digit the state moves to SPACE.
  - SPACE: SP moves to FIELD_B.
  - FIELD_B: after the 4th digit the state moves to EOL.
  - EOL: TERM commits the record and moves to HUNT.
  - Any unexpected byte in FIELD_A, SPACE, FIELD_B or EOL is an error and moves to SKIP.
  - SKIP: all bytes are discarded until TERM, which moves to HUNT.
REQ-017 Field checks at commit: D0 > 3 or D1 > 1 is an error, and the record is not committed.
REQ-018 Commit latency: record, the field outputs and record_strobe update on the clock edge after the TERM byte is sampled, i.e. one cycle after the data_strobe cycle.
REQ-019 On error, error_strobe pulses one cycle after the offending byte is sampled, and error_count increments unless it is saturated.
REQ-020 record and the field outputs hold their value between commits; a malformed line never alters them.
REQ-021 A second TERM (for example "\n\r") lands in HUNT and is silently ignored, so it causes no error and no strobe.
REQ-022 Cycles without data_strobe change no state; bytes arriving on back-to-back cycles are all processed.
REQ-023 Neither record_strobe nor error_strobe is ever asserted for more than one cycle, and the two are never asserted in the same cycle.

Reset
REQ-024 Asserting reset forces, asynchronously:
  - state = HUNT, digit counter = 0, shift register = 0;
  - record, field outputs, record_strobe, error_strobe and error_count = 0.
REQ-025 Reset during a partial line discards that line; parsing resumes at the first hex digit after reset is released.

Structure
REQ-026 A shared package holds the ASCII constants (SP, LF, CR), the record width (28) and the state encoding.
REQ-027 One combinational sub-module, ascii_hex_decode, maps a byte to {valid, nibble[3:0]} and honours ACCEPT_LOWER.
REQ-028 The remaining logic (FSM, shift register, counters) stays in lighthouse_line_rx; the block contains no FIFO.

Verification
REQ-029 Stimulus "31A BCDE\n\r" -> one record_strobe; lighthouse=1, axis=1, data_bit=1, angle=0xABCDE, record=0x31ABCDE, error_count=0.
REQ-030 Stimulus "00a bcde\r" with ACCEPT_LOWER=1 -> angle=0xABCDE, lighthouse=axis=data_bit=0; the same stimulus with ACCEPT_LOWER=0 -> error_strobe, error_count=1, record unchanged.
REQ-031 Stimulus "41A BCDE\n" -> error at commit (D0 > 3), no record_strobe, previous record held; then "201 2345\n" -> record=0x2012345.
REQ-032 Stimulus "31AXBCDE\n00F FFFF\n" -> error_strobe on 'X'; the remainder of the line is skipped; the next line yields angle=0xFFFFF with lighthouse=axis=data_bit=0.
REQ-033 Reset pulsed after "31A BC" -> all outputs 0; then "100 0001\n" -> axis=1, angle=0x00001, exactly one record_strobe.
REQ-034 With ERR_BITS=2, send 5 malformed lines -> 5 error_strobe pulses and error_count saturates at 3.
